// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter and sequencer in front of a banked synchronous data
// memory with a write port (A) and a read port (B, one cycle read latency).
// Port 0 is the CPU load/store unit, port 1 the debug/program loader.
//
// At most one transfer is granted per cycle. The granted request is steered
// combinationally onto memory port A (writes, i_wen != 0) or port B (reads,
// i_wen == 0). A registered tag of the accepted port and operation produces
// the response strobe one cycle later; read data is taken straight from the
// memory output at that point, write responses return zero data.
//
// A requester may hold the bus across several transfers by raising i_lock
// with an accepted transfer. While locked only that port can be granted. The
// lock ends when the owner drops i_lock, or is forcibly released after
// LOCK_MAX locked cycles, which raises o_lock_timeout for one cycle and makes
// the lock owner the last-grant port so the other side goes first.
//
// Build option:
//   DMEM_ARB_ROUND_ROBIN_EN  defined   : contested cycles in ARB alternate
//                                        (grant goes to the port that did
//                                        not win most recently).
//                            undefined : fixed priority, port 0 always wins
//                                        in ARB; the last-grant pointer is
//                                        only moved by a lock timeout.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid[1:0]          request valid per port
//   o_ready[1:0]          request accepted this cycle (valid && ready)
//   i_wen                 per-port byte write enables, all-zero = read
//   i_addr                per-port byte address (passed through as-is)
//   i_wdata               per-port write data
//   i_lock[1:0]           keep the grant after this transfer
//   o_resp_valid[1:0]     one response strobe per accepted transfer
//   o_rdata               shared response data, qualified by o_resp_valid
//   o_lock_timeout        one-cycle pulse on forced lock release
//   o_mea/o_wea/o_adra/o_da   memory write port
//   o_meb/o_adrb          memory read port
//   i_qb                  memory read data, valid the cycle after o_meb
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int LOCK_MAX      = 255
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [1:0]                      i_valid,
    output logic [1:0]                      o_ready,
    input  logic [2*(DATA_WIDTH/8)-1:0]     i_wen,
    input  logic [2*ADDRESS_WIDTH-1:0]      i_addr,
    input  logic [2*DATA_WIDTH-1:0]         i_wdata,
    input  logic [1:0]                      i_lock,
    output logic [1:0]                      o_resp_valid,
    output logic [DATA_WIDTH-1:0]           o_rdata,
    output logic                            o_lock_timeout,
    output logic                            o_mea,
    output logic [DATA_WIDTH/8-1:0]         o_wea,
    output logic [ADDRESS_WIDTH-1:0]        o_adra,
    output logic [DATA_WIDTH-1:0]           o_da,
    output logic                            o_meb,
    output logic [ADDRESS_WIDTH-1:0]        o_adrb,
    input  logic [DATA_WIDTH-1:0]           i_qb
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_MAX_CNT = CNT_WIDTH'(LOCK_MAX);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_reg,        state_next;
    logic                   last_grant_reg,   last_grant_next;
    logic [CNT_WIDTH-1:0]   lock_cnt_reg,     lock_cnt_next;
    logic                   lock_timeout_reg, lock_timeout_next;
    logic [1:0]             resp_valid_reg;
    logic                   resp_read_reg;

    // ------------------------------------------------------------------
    // Per-port views of the packed request buses
    // ------------------------------------------------------------------
    logic [BE_WIDTH-1:0]       port_wen   [2];
    logic [ADDRESS_WIDTH-1:0]  port_addr  [2];
    logic [DATA_WIDTH-1:0]     port_wdata [2];
    logic [1:0]                grant;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign port_wen[gi]     = i_wen[gi*BE_WIDTH +: BE_WIDTH];
            assign port_addr[gi]    = i_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign port_wdata[gi]   = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign o_ready[gi]      = grant[gi];
            assign o_resp_valid[gi] = resp_valid_reg[gi];
        end
    endgenerate

    // Grant is one-hot or zero, so bit 1 alone identifies the winner.
    logic                      accept;
    logic                      gnt_port;
    logic                      lock_port;
    logic [BE_WIDTH-1:0]       sel_wen;
    logic [ADDRESS_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]     sel_wdata;
    logic                      is_write;
    logic                      is_read;
    logic [CNT_WIDTH-1:0]      lock_cnt_inc;

    assign accept       = |grant;
    assign gnt_port     = grant[1];
    assign lock_port    = (state_reg == ST_LOCK1);
    assign sel_wen      = port_wen[gnt_port];
    assign sel_addr     = port_addr[gnt_port];
    assign sel_wdata    = port_wdata[gnt_port];
    assign is_write     = accept & (|sel_wen);
    assign is_read      = accept & ~(|sel_wen);
    assign lock_cnt_inc = lock_cnt_reg + 1'b1;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg        <= ST_ARB;
            last_grant_reg   <= 1'b1;
            lock_cnt_reg     <= '0;
            lock_timeout_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            last_grant_reg   <= last_grant_next;
            lock_cnt_reg     <= lock_cnt_next;
            lock_timeout_reg <= lock_timeout_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        lock_cnt_next     = lock_cnt_reg;
        last_grant_next   = last_grant_reg;
        lock_timeout_next = 1'b0;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (accept) begin
            last_grant_next = gnt_port;
        end
`endif

        case (state_reg)
            ST_ARB: begin
                if (accept && i_lock[gnt_port]) begin
                    state_next    = gnt_port ? ST_LOCK1 : ST_LOCK0;
                    lock_cnt_next = '0;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                lock_cnt_next = lock_cnt_inc;
                // The bound wins over a simultaneous voluntary release so
                // the owner always gets flagged when it used the full budget.
                if (lock_cnt_inc == LOCK_MAX_CNT) begin
                    state_next        = ST_ARB;
                    lock_cnt_next     = '0;
                    lock_timeout_next = 1'b1;
                    last_grant_next   = lock_port;
                end else if (!i_lock[lock_port]) begin
                    // i_lock is watched even when the owner is idle, so an
                    // owner can release without issuing another transfer.
                    state_next    = ST_ARB;
                    lock_cnt_next = '0;
                end
            end
            default: begin
                state_next    = ST_ARB;
                lock_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (grant)
    // ------------------------------------------------------------------
    // Gated by i_rst_n so nothing reaches the memory while reset is held.
    always_comb begin
        grant = 2'b00;
        if (i_rst_n) begin
            case (state_reg)
                ST_ARB: begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    if (i_valid == 2'b11) begin
                        grant = last_grant_reg ? 2'b01 : 2'b10;
                    end else begin
                        grant = i_valid;
                    end
`else
                    if (i_valid[0]) begin
                        grant = 2'b01;
                    end else if (i_valid[1]) begin
                        grant = 2'b10;
                    end
`endif
                end
                ST_LOCK0: grant = {1'b0, i_valid[0]};
                ST_LOCK1: grant = {i_valid[1], 1'b0};
                default:  grant = 2'b00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory port steering (combinational, zero when idle)
    // ------------------------------------------------------------------
    assign o_mea  = is_write;
    assign o_wea  = is_write ? sel_wen   : '0;
    assign o_adra = is_write ? sel_addr  : '0;
    assign o_da   = is_write ? sel_wdata : '0;
    assign o_meb  = is_read;
    assign o_adrb = is_read  ? sel_addr  : '0;

    // ------------------------------------------------------------------
    // Response tag: which port was accepted and whether it was a read
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            resp_valid_reg <= 2'b00;
            resp_read_reg  <= 1'b0;
        end else begin
            resp_valid_reg <= grant;
            resp_read_reg  <= is_read;
        end
    end

    // resp_read_reg can only be set alongside a response strobe, so it
    // alone qualifies the read data; writes answer with zero.
    assign o_rdata        = resp_read_reg ? i_qb : '0;
    assign o_lock_timeout = lock_timeout_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Request side
    logic [1:0]    valid;
    logic [1:0]    lock;
    logic [BW-1:0] wen0, wen1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    // DUT outputs
    logic [1:0]    ready;
    logic [1:0]    resp_valid;
    logic [DW-1:0] rdata;
    logic          lock_to;
    logic          mea;
    logic [BW-1:0] wea;
    logic [AW-1:0] adra;
    logic [DW-1:0] da;
    logic          meb;
    logic [AW-1:0] adrb;
    logic [DW-1:0] qb;

    dmem_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .LOCK_MAX      (255)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (valid),
        .o_ready        (ready),
        .i_wen          ({wen1, wen0}),
        .i_addr         ({addr1, addr0}),
        .i_wdata        ({wdata1, wdata0}),
        .i_lock         (lock),
        .o_resp_valid   (resp_valid),
        .o_rdata        (rdata),
        .o_lock_timeout (lock_to),
        .o_mea          (mea),
        .o_wea          (wea),
        .o_adra         (adra),
        .o_da           (da),
        .o_meb          (meb),
        .o_adrb         (adrb),
        .i_qb           (qb)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Memory model: write port A, registered read port B.
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= DW'(32'h1000_0000 + i);
        end else begin
            if (mea) mem[adra[5:0]] <= merge(mem[adra[5:0]], da, wea);
            if (meb) qb <= mem[adrb[5:0]];
        end
    end

    // Reference contents and response scoreboard
    logic [DW-1:0] ref_mem [64];
    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } resp_t;
    resp_t sb_q[$];

    int tests = 0;
    int fails = 0;

    task automatic init_ref();
        for (int i = 0; i < 64; i++) ref_mem[i] = DW'(32'h1000_0000 + i);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs already driven (we are just after a negedge).
    task automatic tick(input logic [1:0] exp_ready, input logic exp_to);
        logic          g;
        logic [BW-1:0] w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        resp_t         e;
        #1;
        chk("o_ready", 64'(ready), 64'(exp_ready));
        chk("o_lock_timeout", 64'(lock_to), 64'(exp_to));
        g = exp_ready[1];
        w = g ? wen1 : wen0;
        a = g ? addr1 : addr0;
        d = g ? wdata1 : wdata0;
        if (exp_ready != 2'b00 && w != '0) begin
            chk("o_mea", 64'(mea), 64'(1'b1));
            chk("o_wea", 64'(wea), 64'(w));
            chk("o_adra", 64'(adra), 64'(a));
            chk("o_da", 64'(da), 64'(d));
            chk("o_meb", 64'(meb), 64'(1'b0));
            ref_mem[a[5:0]] = merge(ref_mem[a[5:0]], d, w);
            e.port = g;
            e.data = '0;
            sb_q.push_back(e);
        end else if (exp_ready != 2'b00) begin
            chk("o_meb", 64'(meb), 64'(1'b1));
            chk("o_adrb", 64'(adrb), 64'(a));
            chk("o_mea", 64'(mea), 64'(1'b0));
            e.port = g;
            e.data = ref_mem[a[5:0]];
            sb_q.push_back(e);
        end else begin
            chk("idle o_mea", 64'(mea), 64'(1'b0));
            chk("idle o_meb", 64'(meb), 64'(1'b0));
            chk("idle o_wea", 64'(wea), 64'(0));
        end
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("o_resp_valid", 64'(resp_valid), 64'(e.port ? 2'b10 : 2'b01));
            chk("o_rdata", 64'(rdata), 64'(e.data));
            $display("[TB] t=%0t resp port=%0d data=0x%08h (exp 0x%08h)", $time, e.port, rdata, e.data);
        end else begin
            chk("o_resp_valid idle", 64'(resp_valid), 64'(2'b00));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        valid  = 2'b11;
        lock   = 2'b00;
        wen0   = '0;
        wen1   = '0;
        addr0  = '0;
        addr1  = '0;
        wdata0 = '0;
        wdata1 = '0;
        init_ref();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, with requests already present
        chk("rst o_ready", 64'(ready), 64'(2'b00));
        chk("rst o_resp_valid", 64'(resp_valid), 64'(2'b00));
        chk("rst o_rdata", 64'(rdata), 64'(0));
        chk("rst o_lock_timeout", 64'(lock_to), 64'(1'b0));
        chk("rst o_mea", 64'(mea), 64'(1'b0));
        chk("rst o_meb", 64'(meb), 64'(1'b0));
        chk("rst o_wea", 64'(wea), 64'(0));
        chk("rst o_adra", 64'(adra), 64'(0));
        chk("rst o_da", 64'(da), 64'(0));
        chk("rst o_adrb", 64'(adrb), 64'(0));
        rst_n = 1'b1;

        // Both ports read continuously
        valid = 2'b11; addr0 = 32'h0; addr1 = 32'h4;
        tick(2'b01, 1'b0);
        tick(RR ? 2'b10 : 2'b01, 1'b0);
        tick(2'b01, 1'b0);
        tick(RR ? 2'b10 : 2'b01, 1'b0);

        // Write then read back on port 0
        valid = 2'b01; wen0 = 4'hF; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        tick(2'b01, 1'b0);
        wen0 = 4'h0;
        tick(2'b01, 1'b0);
        valid = 2'b00;
        tick(2'b00, 1'b0);

        // Misaligned partial write then read on port 1
        valid = 2'b10; wen1 = 4'h3; addr1 = 32'h3; wdata1 = 32'h0000A55A;
        tick(2'b10, 1'b0);
        wen1 = 4'h0;
        tick(2'b10, 1'b0);
        valid = 2'b00;
        tick(2'b00, 1'b0);

        // Port 1 lock for three transfers, port 0 blocked until release
        valid = 2'b10; lock = 2'b10; addr1 = 32'h4; addr0 = 32'h0;
        tick(2'b10, 1'b0);
        valid = 2'b11;
        tick(2'b10, 1'b0);
        tick(2'b10, 1'b0);
        valid = 2'b01; lock = 2'b00;
        tick(2'b00, 1'b0);
        tick(2'b01, 1'b0);
        valid = 2'b00;
        tick(2'b00, 1'b0);

        // Port 0 holds the lock past the bound
        valid = 2'b01; lock = 2'b01;
        tick(2'b01, 1'b0);
        valid = 2'b11;
        for (int k = 0; k < 255; k++) tick(2'b01, 1'b0);
        tick(RR ? 2'b10 : 2'b01, 1'b1);
        valid = 2'b00; lock = 2'b00;
        tick(2'b00, 1'b0);
        tick(2'b00, 1'b0);

        // Reset asserted right after a read accept
        valid = 2'b01; addr0 = 32'h0;
        #1;
        chk("pre-rst o_ready", 64'(ready), 64'(2'b01));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-rst o_resp_valid", 64'(resp_valid), 64'(2'b00));
        chk("mid-rst o_rdata", 64'(rdata), 64'(0));
        chk("mid-rst o_meb", 64'(meb), 64'(1'b0));
        chk("mid-rst o_ready", 64'(ready), 64'(2'b00));
        @(negedge clk);
        chk("mid-rst resp hold", 64'(resp_valid), 64'(2'b00));
        init_ref();
        @(negedge clk);
        rst_n = 1'b1;
        valid = 2'b11; addr1 = 32'h4;
        tick(2'b01, 1'b0);
        valid = 2'b00;
        tick(2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
